// File: rtl/pipe_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the load-use stall sequencer and its neighbours:
//   stall_st_t : sequencer state (IDLE, WAIT, RELEASE)
//   REG_ZERO   : hard-wired zero register, never a real hazard source
//   OP_LW      : load-word opcode as seen by the decode stage
//   NOP_CTRL   : ID/EX control word of a bubble (every control bit cleared)
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } stall_st_t;

  localparam logic [3:0] REG_ZERO = 4'h0;
  localparam logic [3:0] OP_LW    = 4'b1000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [3:0] alu_op;
  } idex_ctrl_t;

  localparam idex_ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Parameters: W - counter width
// Ports:
//   clk   in  : clock, rising edge
//   rst_n in  : asynchronous active-low reset, clears the count
//   inc   in  : count up this cycle (ignored once saturated)
//   clear in  : synchronous clear, wins over inc
//   value out : current count
// -----------------------------------------------------------------------------
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Load-use stall sequencer. Turns a hazard-unit stall request on a load into
// held PC / IF/ID enables plus an ID/EX bubble, waits for the load's register
// write-back, then pulses write_done for one cycle so the hazard unit drops
// its request.
//
// Optional feature macro: PIPE_STALL_TIMEOUT_EN
//   When defined, a WAIT lasting MAX_STALL cycles without the matching
//   write-back is released anyway and the sticky timeout_err flag is set.
//
// Parameters: MAX_STALL (1..15) WAIT cycles before forced release,
//             CNT_W width of the stall-cycle performance counter.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   hz_pc_stall/ifid/idex      : stall requests from the hazard unit
//   e_isLoad, e_wreg           : EX-stage load flag and destination register
//   w_wen, w_waddr             : write-back register-file write port
//   pc_en, ifid_en             : pipeline register enables
//   idex_bubble                : load a NOP into ID/EX
//   write_done                 : one-cycle release pulse to the hazard unit
//   stall_busy                 : sequencer is waiting for the write-back
//   stall_cycles               : saturating count of cycles with pc_en low
//   timeout_err (feature only) : sticky forced-release flag
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_STALL = 7,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_pc_stall,
  input  logic             hz_ifid_stall,
  input  logic             hz_idex_stall,
  input  logic             e_isLoad,
  input  logic [3:0]       e_wreg,
  input  logic             w_wen,
  input  logic [3:0]       w_waddr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_bubble,
  output logic             write_done,
  output logic             stall_busy,
  output logic [CNT_W-1:0] stall_cycles
`ifdef PIPE_STALL_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  // Wide enough to hold MAX_STALL-1; wraps harmlessly when no timeout is used.
  localparam int WCNT_W = $clog2(MAX_STALL + 1);

  stall_st_t          state_q, state_d;
  logic [3:0]         pend_reg_q, pend_reg_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               write_done_q, write_done_d;
  logic               req;
  logic               match;

  assign req   = (hz_pc_stall | hz_ifid_stall | hz_idex_stall) & e_isLoad &
                 (e_wreg != REG_ZERO);
  assign match = w_wen & (w_waddr == pend_reg_q);

`ifdef PIPE_STALL_TIMEOUT_EN
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_STALL - 1);
  logic timeout_q, timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    pend_reg_d   = pend_reg_q;
    wait_cnt_d   = wait_cnt_q;
    write_done_d = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_bubble  = 1'b0;
`ifdef PIPE_STALL_TIMEOUT_EN
    timeout_d    = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Zero-latency stall: the request itself holds the pipe this cycle.
        pc_en       = ~req;
        ifid_en     = ~req;
        idex_bubble = req;
        if (req) begin
          pend_reg_d = e_wreg;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        if (match) begin
          state_d      = RELEASE;
          write_done_d = 1'b1;
`ifdef PIPE_STALL_TIMEOUT_EN
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d      = RELEASE;
          write_done_d = 1'b1;
          timeout_d    = 1'b1;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        // Enables are already high; a request seen here is re-evaluated in IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_reg_q   <= REG_ZERO;
      wait_cnt_q   <= '0;
      write_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_reg_q   <= pend_reg_d;
      wait_cnt_q   <= wait_cnt_d;
      write_done_q <= write_done_d;
    end
  end

`ifdef PIPE_STALL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`endif

  // write_done is set on the WAIT->RELEASE transition, so it is high exactly
  // for the single RELEASE cycle.
  assign write_done = write_done_q;
  assign stall_busy = (state_q == WAIT);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_en),
    .clear (1'b0),
    .value (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  localparam int MAX_STALL = 4;
  localparam int CNT_W     = 4;
  localparam int SC_MAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [2:0]       hz;
  logic             e_isLoad;
  logic [3:0]       e_wreg;
  logic             w_wen;
  logic [3:0]       w_waddr;
  logic             pc_en, ifid_en, idex_bubble, write_done, stall_busy;
  logic [CNT_W-1:0] stall_cycles;
`ifdef PIPE_STALL_TIMEOUT_EN
  logic             timeout_err;
`endif
  logic [4:0]       dut_outs;

  pipe_stall_ctrl #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hz_pc_stall   (hz[0]),
    .hz_ifid_stall (hz[1]),
    .hz_idex_stall (hz[2]),
    .e_isLoad      (e_isLoad),
    .e_wreg        (e_wreg),
    .w_wen         (w_wen),
    .w_waddr       (w_waddr),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_bubble   (idex_bubble),
    .write_done    (write_done),
    .stall_busy    (stall_busy),
    .stall_cycles  (stall_cycles)
`ifdef PIPE_STALL_TIMEOUT_EN
    ,
    .timeout_err   (timeout_err)
`endif
  );

  // {pc_en, ifid_en, idex_bubble, write_done, stall_busy}
  assign dut_outs = {pc_en, ifid_en, idex_bubble, write_done, stall_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks the episode: which register is awaited (-1 = none), how many WAIT
  // cycles have elapsed, and whether a release cycle is owed next.
  int m_pend;
  int m_waited;
  bit m_rel;
  int m_sc;
  bit m_terr;

  task automatic model_reset();
    m_pend = -1; m_waited = 0; m_rel = 0; m_sc = 0; m_terr = 0;
  endtask

  // Expected outputs for the current cycle's inputs, then advance one cycle.
  task automatic model_eval(output logic [4:0] eo, output logic [3:0] esc, output logic eterr);
    bit r;
    esc   = m_sc[3:0];
    eterr = m_terr;
    if (m_rel) begin
      eo    = 5'b11010;
      m_rel = 0;
    end else if (m_pend >= 0) begin
      eo = 5'b00101;
      m_waited++;
      if (w_wen && (int'(w_waddr) == m_pend)) begin
        m_rel = 1; m_pend = -1;
`ifdef PIPE_STALL_TIMEOUT_EN
      end else if (m_waited == MAX_STALL) begin
        m_rel = 1; m_pend = -1; m_terr = 1;
`endif
      end
    end else begin
      r  = (hz != 3'b000) && e_isLoad && (e_wreg != 4'd0);
      eo = r ? 5'b00100 : 5'b11000;
      if (r) begin
        m_pend = int'(e_wreg); m_waited = 0;
      end
    end
    if (!eo[4] && m_sc < SC_MAX) m_sc++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic apply(input logic [2:0] h, input logic l, input logic [3:0] r,
                       input logic we, input logic [3:0] wa);
    hz = h; e_isLoad = l; e_wreg = r; w_wen = we; w_waddr = wa;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One cycle checked against constants written by hand.
  task automatic hand(input string name, input logic [2:0] h, input logic l, input logic [3:0] r,
                      input logic we, input logic [3:0] wa,
                      input logic [4:0] exp_o, input logic [3:0] exp_sc, input logic exp_terr);
    logic [4:0] eo; logic [3:0] esc; logic et;
    apply(h, l, r, we, wa);
    model_eval(eo, esc, et);
    chk({name, " outs"}, dut_outs, exp_o);
    chk({name, " stall_cycles"}, stall_cycles, exp_sc);
`ifdef PIPE_STALL_TIMEOUT_EN
    chk({name, " timeout_err"}, timeout_err, exp_terr);
`else
    if (exp_terr) $display("[TB] note: timeout expectation in build without timeout");
`endif
    $display("[TB] %s hz=%b ld=%b wreg=%0d wen=%b waddr=%0d outs=%b sc=%0d",
             name, h, l, r, we, wa, dut_outs, stall_cycles);
    next_cycle();
  endtask

  // One cycle checked against the reference model.
  task automatic mstep(input string name, input logic [2:0] h, input logic l, input logic [3:0] r,
                       input logic we, input logic [3:0] wa);
    logic [4:0] eo; logic [3:0] esc; logic et;
    apply(h, l, r, we, wa);
    model_eval(eo, esc, et);
    chk({name, " outs"}, dut_outs, eo);
    chk({name, " stall_cycles"}, stall_cycles, esc);
`ifdef PIPE_STALL_TIMEOUT_EN
    chk({name, " timeout_err"}, timeout_err, et);
`endif
    $display("[TB] %s hz=%b ld=%b wreg=%0d wen=%b waddr=%0d outs=%b sc=%0d",
             name, h, l, r, we, wa, dut_outs, stall_cycles);
    next_cycle();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0] hz;
    logic       ld;
    logic [3:0] wreg;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] exp_o;
    logic [3:0] exp_sc;
  } vec_t;

  function automatic vec_t mk(logic [2:0] h, logic l, logic [3:0] r, logic we,
                              logic [3:0] wa, logic [4:0] eo, logic [3:0] sc);
    vec_t v;
    v.hz = h; v.ld = l; v.wreg = r; v.wen = we; v.waddr = wa; v.exp_o = eo; v.exp_sc = sc;
    return v;
  endfunction

  localparam int NVEC = 22;
  vec_t tbl[NVEC];

  initial begin
    // basic load-use: request on r3, write-back of r3 two cycles later
    tbl[0]  = mk(3'b000, 0, 0, 0, 0, 5'b11000, 0);
    tbl[1]  = mk(3'b001, 1, 3, 0, 0, 5'b00100, 0);
    tbl[2]  = mk(3'b000, 0, 0, 0, 0, 5'b00101, 1);
    tbl[3]  = mk(3'b000, 0, 0, 1, 3, 5'b00101, 2);
    tbl[4]  = mk(3'b000, 0, 0, 0, 0, 5'b11010, 3);
    tbl[5]  = mk(3'b000, 0, 0, 0, 0, 5'b11000, 3);
    // R0 filter and non-load requests
    tbl[6]  = mk(3'b001, 1, 0, 0, 0, 5'b11000, 3);
    tbl[7]  = mk(3'b111, 1, 0, 0, 0, 5'b11000, 3);
    tbl[8]  = mk(3'b010, 0, 5, 0, 0, 5'b11000, 3);
    // wrong write-back r5 while waiting on r3, wen low with right address
    tbl[9]  = mk(3'b100, 1, 3, 0, 0, 5'b00100, 3);
    tbl[10] = mk(3'b000, 0, 0, 1, 5, 5'b00101, 4);
    tbl[11] = mk(3'b000, 0, 0, 0, 3, 5'b00101, 5);
    tbl[12] = mk(3'b000, 0, 0, 1, 3, 5'b00101, 6);
    tbl[13] = mk(3'b000, 0, 0, 0, 0, 5'b11010, 7);
    // entry-cycle match ignored, then back-to-back with request held in RELEASE
    tbl[14] = mk(3'b010, 1, 6, 1, 6, 5'b00100, 7);
    tbl[15] = mk(3'b000, 0, 0, 1, 6, 5'b00101, 8);
    tbl[16] = mk(3'b001, 1, 9, 0, 0, 5'b11010, 9);
    tbl[17] = mk(3'b001, 1, 9, 0, 0, 5'b00100, 9);
    tbl[18] = mk(3'b001, 1, 9, 1, 6, 5'b00101, 10);
    tbl[19] = mk(3'b001, 1, 9, 1, 9, 5'b00101, 11);
    tbl[20] = mk(3'b000, 0, 0, 0, 0, 5'b11010, 12);
    tbl[21] = mk(3'b000, 0, 0, 0, 0, 5'b11000, 12);
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    hz = 3'b000; e_isLoad = 1'b0; e_wreg = 4'd0; w_wen = 1'b0; w_waddr = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", dut_outs, 5'b11000);
    chk("reset stall_cycles", stall_cycles, 0);
`ifdef PIPE_STALL_TIMEOUT_EN
    chk("reset timeout_err", timeout_err, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      hand($sformatf("vec%0d", i), tbl[i].hz, tbl[i].ld, tbl[i].wreg, tbl[i].wen,
           tbl[i].waddr, tbl[i].exp_o, tbl[i].exp_sc, 1'b0);
    end

`ifdef PIPE_STALL_TIMEOUT_EN
    // forced release after MAX_STALL WAIT cycles; counter saturates on the way
    hand("to_entry", 3'b001, 1, 5, 0, 0, 5'b00100, 12, 0);
    hand("to_wait1", 3'b000, 0, 0, 0, 0, 5'b00101, 13, 0);
    hand("to_wait2", 3'b000, 0, 0, 1, 4, 5'b00101, 14, 0);
    hand("to_wait3", 3'b000, 0, 0, 0, 0, 5'b00101, 15, 0);
    hand("to_wait4", 3'b000, 0, 0, 0, 0, 5'b00101, 15, 0);
    hand("to_rel",   3'b000, 0, 0, 0, 0, 5'b11010, 15, 1);
    hand("to_idle",  3'b000, 0, 0, 0, 0, 5'b11000, 15, 1);
    hand("to_entry2", 3'b010, 1, 2, 0, 0, 5'b00100, 15, 1);
    hand("to_match2", 3'b000, 0, 0, 1, 2, 5'b00101, 15, 1);
    hand("to_rel2",  3'b000, 0, 0, 0, 0, 5'b11010, 15, 1);
    hand("to_idle2", 3'b000, 0, 0, 0, 0, 5'b11000, 15, 1);
`endif

    // reset asserted in the second WAIT cycle
    mstep("rst_entry", 3'b001, 1, 7, 0, 0);
    mstep("rst_wait1", 3'b000, 0, 0, 0, 0);
    hz = 3'b000; e_isLoad = 1'b0; e_wreg = 4'd0; w_wen = 1'b0; w_waddr = 4'd0;
    #1;
    chk("rst_wait2 busy", dut_outs, 5'b00101);
    rst_n = 1'b0;
    #1;
    chk("rst_async outs", dut_outs, 5'b11000);
    chk("rst_async stall_cycles", stall_cycles, 0);
`ifdef PIPE_STALL_TIMEOUT_EN
    chk("rst_async timeout_err", timeout_err, 0);
`endif
    $display("[TB] reset mid-wait outs=%b sc=%0d", dut_outs, stall_cycles);
    model_reset();
    next_cycle();
    chk("rst_held outs", dut_outs, 5'b11000);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) mstep($sformatf("post_rst%0d", i), 3'b000, 0, 0, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [2:0] h; logic l; logic [3:0] r; logic we; logic [3:0] wa;
      h  = 3'($urandom_range(0, 7));
      l  = ($urandom_range(0, 9) < 7);
      r  = 4'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 3));
      mstep($sformatf("rnd%0d", i), h, l, r, we, wa);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Load-use stall sequencer: the consumer of the hazard unit's stall requests and the producer of its `write_done` release. It sits between the hazard unit and the PC, IF/ID and ID/EX pipeline registers. It turns a stall request into held enables plus a NOP bubble. It tracks the offending load until its register write-back completes, then pulses `write_done` for one cycle so the hazard unit drops the request.

## Interface
- `MAX_STALL`, default 7: WAIT cycles before forced release. Used only with the timeout feature; legal range 1..15.
- `CNT_W`, default 16: width of the saturating stall-cycle performance counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `hz_pc_stall`, `hz_ifid_stall`, `hz_idex_stall` in 1 each: stall requests from the hazard unit.
- `e_isLoad` in 1: the EX-stage instruction is a load.
- `e_wreg` in 4: EX-stage destination register.
- `w_wen` in 1: register-file write enable in write-back.
- `w_waddr` in 4: register-file write address in write-back.
- `pc_en` out 1: PC update enable.
- `ifid_en` out 1: IF/ID register load enable.
- `idex_bubble` out 1: load a NOP (all control bits 0) into ID/EX.
- `write_done` out 1: one-cycle release pulse to the hazard unit.
- `stall_busy` out 1: FSM is in WAIT.
- `stall_cycles` out CNT_W: count of cycles with `pc_en`=0, saturating.
- `timeout_err` out 1: sticky flag. Exists only with the timeout feature.

## Operation
- FSM has three states: IDLE, WAIT, RELEASE.
- Stall request: `req` = (`hz_pc_stall` | `hz_ifid_stall` | `hz_idex_stall`) & `e_isLoad` & (`e_wreg` != 0).
- **IDLE**
  - Outputs combinational: `pc_en`=!req, `ifid_en`=!req, `idex_bubble`=req.
  - On req: capture `pend_reg`<=`e_wreg`, clear `wait_cnt`, go to WAIT.
  - A request with `e_wreg`==0 is ignored: no stall, stays IDLE.
- **WAIT**
  - Outputs forced: `pc_en`=0, `ifid_en`=0, `idex_bubble`=1. Hazard inputs are ignored.
  - Match = `w_wen` & (`w_waddr`==`pend_reg`). On match, go to RELEASE.
  - Otherwise `wait_cnt`++ and stay in WAIT.
- **RELEASE**
  - Outputs: `write_done`=1, `pc_en`=1, `ifid_en`=1, `idex_bubble`=0. Hazard inputs are ignored.
  - Unconditionally returns to IDLE next cycle.
- `write_done` is registered. It is 1 only in RELEASE, for exactly one cycle per stall episode.
- `stall_cycles` increments each cycle in which `pc_en`=0. It saturates at all-ones.
- `stall_busy` = (state==WAIT).

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state IDLE, `pc_en`=1, `ifid_en`=1, `idex_bubble`=0, `write_done`=0.
  - `pend_reg`=0, `wait_cnt`=0, `stall_cycles`=0, `timeout_err`=0.
- Stall takes effect in the same cycle as `req`, with zero latency, via the combinational IDLE path.
- Release latency: the match is seen in cycle N, `write_done`=1 and enables high in N+1, IDLE in N+2.
- Minimum episode is 1 WAIT cycle then 1 RELEASE cycle. Total `pc_en`=0 is 2 cycles (entry cycle plus WAIT).
- Match in the same cycle as IDLE entry is ignored; entry has priority.
- A write-back to a different register in WAIT does not release.
- `req` during RELEASE is ignored. A new request is evaluated in IDLE on the next cycle.
- Reset asserted mid-WAIT aborts the episode: no `write_done` pulse and enables return high.

## Configuration
- Macro: `PIPE_STALL_TIMEOUT_EN`.
- Defined:
  - In WAIT, when `wait_cnt`==`MAX_STALL`-1 with no match, go to RELEASE anyway.
  - Set `timeout_err` (sticky until reset). `write_done` still pulses.
- Undefined:
  - WAIT persists until a match.
  - `timeout_err` port absent and `MAX_STALL` unused.

## Structure
- Shared package `pipe_pkg`:
  - state enum `stall_st_t` {IDLE, WAIT, RELEASE};
  - `REG_ZERO`=4'h0;
  - `OP_LW`=4'b1000;
  - NOP control constant.
- Sub-module `sat_counter` (parameter W; inc, clear, value) for `stall_cycles`.
- `wait_cnt` stays local to the FSM.

## Test plan
- **Basic load-use:** `req` with `e_wreg`=3; `w_wen`=1, `w_waddr`=3 two cycles later.
  - `pc_en`=0 for 3 cycles.
  - `write_done` pulses once, then IDLE.
  - `stall_cycles`=3.
- **R0 filter:** `hz_pc_stall`=1, `e_isLoad`=1, `e_wreg`=0.
  - `pc_en` stays 1, no state change, `write_done` never asserts.
- **Wrong write-back:** in WAIT, `w_waddr`=5 with `pend_reg`=3.
  - Stays WAIT.
  - A later `w_waddr`=3 releases.
- **Back-to-back:** new `req` held high through RELEASE.
  - Ignored in RELEASE.
  - Re-entered WAIT the following cycle with the new `pend_reg`.
- **Reset mid-stall:** `rst_n` low in the second WAIT cycle.
  - Outputs go to reset values immediately.
  - No `write_done` pulse.
- **Timeout** (`PIPE_STALL_TIMEOUT_EN`, `MAX_STALL`=4): no match.
  - RELEASE after 4 WAIT cycles.
  - `timeout_err`=1 and stays 1 until reset.
